// File: rtl/tlul_host_arb_m1.sv
`default_nettype none
// ============================================================================
// Module   : tlul_host_arb_m1
// Purpose  : M:1 TL-UL socket. Several TL-UL hosts share one device port
//            through a round-robin arbiter. The grant is held while a request
//            is stalled, and each host may have only a limited number of
//            unanswered requests. The host index is tagged into the low bits
//            of a_source so that responses can be steered back. The request
//            path has zero latency and no FIFO.
// Ports    : clk_i / rst_i   clock, synchronous active-high reset
//            tl_h_*_i        host A-channel fields and d_ready, flattened so
//                            that host i owns slice [i*W +: W]
//            tl_h_*_o        per-host a_ready and D-channel responses
//            tl_d_*_o        device A-channel request and d_ready
//            tl_d_*_i        device a_ready and D-channel response
//            grant_o         one-hot host driving the device (0 when idle)
//            busy_o          some host still has outstanding requests
// Revision : 1.0  initial release
// ============================================================================
module tlul_host_arb_m1 #(
  parameter int M               = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AIW             = 8,
  parameter int AW              = 32,
  parameter int DW              = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // host side, requests in
  input  logic [M-1:0]         tl_h_a_valid_i,
  input  logic [3*M-1:0]       tl_h_a_opcode_i,
  input  logic [3*M-1:0]       tl_h_a_param_i,
  input  logic [2*M-1:0]       tl_h_a_size_i,
  input  logic [AIW*M-1:0]     tl_h_a_source_i,
  input  logic [AW*M-1:0]      tl_h_a_address_i,
  input  logic [(DW/8)*M-1:0]  tl_h_a_mask_i,
  input  logic [DW*M-1:0]      tl_h_a_data_i,
  input  logic [M-1:0]         tl_h_d_ready_i,
  // host side, responses out
  output logic [M-1:0]         tl_h_a_ready_o,
  output logic [M-1:0]         tl_h_d_valid_o,
  output logic [3*M-1:0]       tl_h_d_opcode_o,
  output logic [3*M-1:0]       tl_h_d_param_o,
  output logic [2*M-1:0]       tl_h_d_size_o,
  output logic [AIW*M-1:0]     tl_h_d_source_o,
  output logic [M-1:0]         tl_h_d_sink_o,
  output logic [DW*M-1:0]      tl_h_d_data_o,
  output logic [M-1:0]         tl_h_d_error_o,
  // device side, request out
  output logic                 tl_d_a_valid_o,
  output logic [2:0]           tl_d_a_opcode_o,
  output logic [2:0]           tl_d_a_param_o,
  output logic [1:0]           tl_d_a_size_o,
  output logic [AIW-1:0]       tl_d_a_source_o,
  output logic [AW-1:0]        tl_d_a_address_o,
  output logic [DW/8-1:0]      tl_d_a_mask_o,
  output logic [DW-1:0]        tl_d_a_data_o,
  output logic                 tl_d_d_ready_o,
  // device side, response in
  input  logic                 tl_d_a_ready_i,
  input  logic                 tl_d_d_valid_i,
  input  logic [2:0]           tl_d_d_opcode_i,
  input  logic [2:0]           tl_d_d_param_i,
  input  logic [1:0]           tl_d_d_size_i,
  input  logic [AIW-1:0]       tl_d_d_source_i,
  input  logic                 tl_d_d_sink_i,
  input  logic [DW-1:0]        tl_d_d_data_i,
  input  logic                 tl_d_d_error_i,
  // status
  output logic [M-1:0]         grant_o,
  output logic                 busy_o
);

  localparam int c_idw = $clog2(M);
  localparam int c_cw  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cw-1:0] c_cnt_max = c_cw'(MAX_OUTSTANDING);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_idw-1:0] r_rr_ptr;
  logic             r_lock;
  logic [c_idw-1:0] r_lock_idx;
  logic [c_cw-1:0]  r_cnt [M];

  logic [M-1:0]     w_elig;
  logic             w_scan_found;
  logic [c_idw-1:0] w_scan_idx;
  logic [c_idw-1:0] w_win_idx;
  logic             w_win_valid;
  logic [M-1:0]     w_win_oh;
  logic [AIW-c_idw-1:0] w_src_low;
  logic [M-1:0]     w_req_acc;
  logic [c_idw-1:0] w_tag;
  logic [M-1:0]     w_tag_oh;
  logic             w_tag_in;
  logic [M-1:0]     w_rsp_acc;
  logic             w_busy;

  // (base + k) mod M, with base < M and k < M
  function automatic logic [c_idw-1:0] f_wrap(input int base, input int k);
    int s;
    s = base + k;
    if (s >= M) s = s - M;
    return c_idw'(s);
  endfunction

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  // A host at its outstanding limit is simply not eligible, so it is passed
  // over without the pointer moving; only an accepted request advances it.
  always_comb begin
    w_elig       = '0;
    w_scan_found = 1'b0;
    w_scan_idx   = '0;
    for (int i = 0; i < M; i++) begin
      w_elig[i] = tl_h_a_valid_i[i] && (r_cnt[i] != c_cnt_max);
    end
    for (int k = 0; k < M; k++) begin
      if (!w_scan_found && w_elig[f_wrap(int'(r_rr_ptr), k)]) begin
        w_scan_found = 1'b1;
        w_scan_idx   = f_wrap(int'(r_rr_ptr), k);
      end
    end
  end

  // A stalled request keeps its grant so the A fields stay stable on the bus.
  assign w_win_idx   = r_lock ? r_lock_idx : w_scan_idx;
  assign w_win_valid = !rst_i && (r_lock ? tl_h_a_valid_i[r_lock_idx] : w_scan_found);

  // --------------------------------------------------------------------------
  // Request path
  // --------------------------------------------------------------------------
  always_comb begin
    w_win_oh         = '0;
    w_src_low        = '0;
    tl_d_a_opcode_o  = '0;
    tl_d_a_param_o   = '0;
    tl_d_a_size_o    = '0;
    tl_d_a_address_o = '0;
    tl_d_a_mask_o    = '0;
    tl_d_a_data_o    = '0;
    for (int i = 0; i < M; i++) begin
      if (w_win_idx == c_idw'(i)) begin
        w_win_oh[i]      = 1'b1;
        w_src_low        = tl_h_a_source_i[i*AIW +: (AIW-c_idw)];
        tl_d_a_opcode_o  = tl_h_a_opcode_i[i*3 +: 3];
        tl_d_a_param_o   = tl_h_a_param_i[i*3 +: 3];
        tl_d_a_size_o    = tl_h_a_size_i[i*2 +: 2];
        tl_d_a_address_o = tl_h_a_address_i[i*AW +: AW];
        tl_d_a_mask_o    = tl_h_a_mask_i[i*(DW/8) +: (DW/8)];
        tl_d_a_data_o    = tl_h_a_data_i[i*DW +: DW];
      end
    end
  end

  assign tl_d_a_valid_o  = w_win_valid;
  assign tl_d_a_source_o = {w_src_low, w_win_idx};
  assign grant_o         = w_win_valid ? w_win_oh : '0;
  assign w_req_acc       = (w_win_valid && tl_d_a_ready_i) ? w_win_oh : '0;
  assign tl_h_a_ready_o  = w_req_acc;

  // --------------------------------------------------------------------------
  // Response path
  // --------------------------------------------------------------------------
  assign w_tag = tl_d_d_source_i[c_idw-1:0];

  always_comb begin
    w_tag_oh = '0;
    for (int i = 0; i < M; i++) begin
      w_tag_oh[i] = (w_tag == c_idw'(i));
    end
  end

  // A tag that names no host can only appear when M is not a power of two;
  // such a response is drained so the device is never wedged.
  assign w_tag_in       = |w_tag_oh;
  assign tl_h_d_valid_o = (!rst_i && tl_d_d_valid_i) ? w_tag_oh : '0;
  assign tl_d_d_ready_o = !rst_i && (w_tag_in ? |(w_tag_oh & tl_h_d_ready_i) : 1'b1);
  assign w_rsp_acc      = tl_h_d_valid_o & tl_h_d_ready_i;

  // D fields are broadcast; only d_valid selects the receiving host.
  assign tl_h_d_opcode_o = {M{tl_d_d_opcode_i}};
  assign tl_h_d_param_o  = {M{tl_d_d_param_i}};
  assign tl_h_d_size_o   = {M{tl_d_d_size_i}};
  assign tl_h_d_source_o = {M{{{c_idw{1'b0}}, tl_d_d_source_i[AIW-1:c_idw]}}};
  assign tl_h_d_sink_o   = {M{tl_d_d_sink_i}};
  assign tl_h_d_data_o   = {M{tl_d_d_data_i}};
  assign tl_h_d_error_o  = {M{tl_d_d_error_i}};

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_win_valid) begin
      if (tl_d_a_ready_i) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= f_wrap(int'(w_win_idx), 1);
      end else begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_win_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < M; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (w_req_acc[i] && !w_rsp_acc[i]) begin
          r_cnt[i] <= r_cnt[i] + c_cw'(1);
        end else if (!w_req_acc[i] && w_rsp_acc[i]) begin
          r_cnt[i] <= r_cnt[i] - c_cw'(1);
        end
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < M; i++) begin
      w_busy = w_busy | (r_cnt[i] != '0);
    end
  end

  assign busy_o = !rst_i && w_busy;

  // --------------------------------------------------------------------------
  // Assertions
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(grant_o));

  a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    r_lock |-> $stable({tl_d_a_valid_o, tl_d_a_opcode_o, tl_d_a_param_o, tl_d_a_size_o,
                        tl_d_a_source_o, tl_d_a_address_o, tl_d_a_mask_o, tl_d_a_data_o}));

  for (genvar gi = 0; gi < M; gi++) begin : g_host_chk
    a_src_upper_zero: assert property (@(posedge clk_i) disable iff (rst_i)
      tl_h_a_valid_i[gi] |-> (tl_h_a_source_i[gi*AIW + AIW - 1 -: c_idw] == '0));
    a_cnt_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      (w_req_acc[gi] && !w_rsp_acc[gi]) |-> (r_cnt[gi] != c_cnt_max));
    a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      (w_rsp_acc[gi] && !w_req_acc[gi]) |-> (r_cnt[gi] != '0));
  end

  if ((1 << c_idw) != M) begin : g_tag_chk
    a_tag_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
      tl_d_d_valid_i |-> w_tag_in);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlul_host_arb_m1.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlul_host_arb_m1
// Purpose  : Scoreboard bench for tlul_host_arb_m1 (M=4, two outstanding per
//            host). Directed stimulus pushes the expected device request or
//            host response; a monitor pops and compares on every cycle the
//            DUT presents a valid A or D beat.
// Revision : 1.0  initial release
// ============================================================================
module tb_tlul_host_arb_m1;

  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [3:0]   tl_h_a_valid_i;
  logic [11:0]  tl_h_a_opcode_i;
  logic [11:0]  tl_h_a_param_i;
  logic [7:0]   tl_h_a_size_i;
  logic [31:0]  tl_h_a_source_i;
  logic [127:0] tl_h_a_address_i;
  logic [15:0]  tl_h_a_mask_i;
  logic [127:0] tl_h_a_data_i;
  logic [3:0]   tl_h_d_ready_i;
  logic [3:0]   tl_h_a_ready_o;
  logic [3:0]   tl_h_d_valid_o;
  logic [11:0]  tl_h_d_opcode_o;
  logic [11:0]  tl_h_d_param_o;
  logic [7:0]   tl_h_d_size_o;
  logic [31:0]  tl_h_d_source_o;
  logic [3:0]   tl_h_d_sink_o;
  logic [127:0] tl_h_d_data_o;
  logic [3:0]   tl_h_d_error_o;
  logic         tl_d_a_valid_o;
  logic [2:0]   tl_d_a_opcode_o;
  logic [2:0]   tl_d_a_param_o;
  logic [1:0]   tl_d_a_size_o;
  logic [7:0]   tl_d_a_source_o;
  logic [31:0]  tl_d_a_address_o;
  logic [3:0]   tl_d_a_mask_o;
  logic [31:0]  tl_d_a_data_o;
  logic         tl_d_d_ready_o;
  logic         tl_d_a_ready_i;
  logic         tl_d_d_valid_i;
  logic [2:0]   tl_d_d_opcode_i;
  logic [2:0]   tl_d_d_param_i;
  logic [1:0]   tl_d_d_size_i;
  logic [7:0]   tl_d_d_source_i;
  logic         tl_d_d_sink_i;
  logic [31:0]  tl_d_d_data_i;
  logic         tl_d_d_error_i;
  logic [3:0]   grant_o;
  logic         busy_o;

  tlul_host_arb_m1 #(.M(4), .MAX_OUTSTANDING(2), .AIW(8), .AW(32), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .tl_h_a_valid_i(tl_h_a_valid_i), .tl_h_a_opcode_i(tl_h_a_opcode_i),
    .tl_h_a_param_i(tl_h_a_param_i), .tl_h_a_size_i(tl_h_a_size_i),
    .tl_h_a_source_i(tl_h_a_source_i), .tl_h_a_address_i(tl_h_a_address_i),
    .tl_h_a_mask_i(tl_h_a_mask_i), .tl_h_a_data_i(tl_h_a_data_i),
    .tl_h_d_ready_i(tl_h_d_ready_i),
    .tl_h_a_ready_o(tl_h_a_ready_o), .tl_h_d_valid_o(tl_h_d_valid_o),
    .tl_h_d_opcode_o(tl_h_d_opcode_o), .tl_h_d_param_o(tl_h_d_param_o),
    .tl_h_d_size_o(tl_h_d_size_o), .tl_h_d_source_o(tl_h_d_source_o),
    .tl_h_d_sink_o(tl_h_d_sink_o), .tl_h_d_data_o(tl_h_d_data_o),
    .tl_h_d_error_o(tl_h_d_error_o),
    .tl_d_a_valid_o(tl_d_a_valid_o), .tl_d_a_opcode_o(tl_d_a_opcode_o),
    .tl_d_a_param_o(tl_d_a_param_o), .tl_d_a_size_o(tl_d_a_size_o),
    .tl_d_a_source_o(tl_d_a_source_o), .tl_d_a_address_o(tl_d_a_address_o),
    .tl_d_a_mask_o(tl_d_a_mask_o), .tl_d_a_data_o(tl_d_a_data_o),
    .tl_d_d_ready_o(tl_d_d_ready_o),
    .tl_d_a_ready_i(tl_d_a_ready_i), .tl_d_d_valid_i(tl_d_d_valid_i),
    .tl_d_d_opcode_i(tl_d_d_opcode_i), .tl_d_d_param_i(tl_d_d_param_i),
    .tl_d_d_size_i(tl_d_d_size_i), .tl_d_d_source_i(tl_d_d_source_i),
    .tl_d_d_sink_i(tl_d_d_sink_i), .tl_d_d_data_i(tl_d_d_data_i),
    .tl_d_d_error_i(tl_d_d_error_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Host source IDs and the hand-computed tagged form seen by the device:
  // {src[5:0], host[1:0]}.
  logic [7:0] hsrc [4] = '{8'h01, 8'h0A, 8'h15, 8'h3F};
  logic [7:0] dsrc [4] = '{8'h04, 8'h29, 8'h56, 8'hFF};

  typedef struct {
    logic [3:0]  grant;
    logic [7:0]  src;
    logic [31:0] addr;
  } a_exp_t;

  typedef struct {
    logic [3:0]  vld;
    int          host;
    logic [7:0]  src;
    logic [31:0] data;
    logic        rdy;
  } d_exp_t;

  a_exp_t a_q[$];
  d_exp_t d_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input int h);
    a_exp_t e;
    e.grant = 4'b0001 << h;
    e.src   = dsrc[h];
    e.addr  = 32'hA000_0000 + 32'(h) * 32'h100;
    a_q.push_back(e);
  endtask

  task automatic respond(input int h, input logic [31:0] data);
    d_exp_t e;
    tl_d_d_valid_i  = 1'b1;
    tl_d_d_source_i = dsrc[h];
    tl_d_d_data_i   = data;
    e.vld  = 4'b0001 << h;
    e.host = h;
    e.src  = hsrc[h];
    e.data = data;
    e.rdy  = tl_h_d_ready_i[h];
    d_q.push_back(e);
  endtask

  task automatic monitor();
    a_exp_t ea;
    d_exp_t ed;
    forever begin
      @(negedge clk);
      if (tl_d_a_valid_o) begin
        if (a_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL a_unexpected: got grant %b, expected no request (t=%0t)", grant_o, $time);
        end else begin
          ea = a_q.pop_front();
          chk("a_grant", grant_o, ea.grant);
          chk("a_source", tl_d_a_source_o, ea.src);
          chk("a_address", tl_d_a_address_o, ea.addr);
        end
      end
      if (|tl_h_d_valid_o) begin
        if (d_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL d_unexpected: got d_valid %b, expected none (t=%0t)", tl_h_d_valid_o, $time);
        end else begin
          ed = d_q.pop_front();
          chk("d_valid_vec", tl_h_d_valid_o, ed.vld);
          chk("d_source", tl_h_d_source_o[ed.host*8 +: 8], ed.src);
          chk("d_data", tl_h_d_data_o[ed.host*32 +: 32], ed.data);
          chk("d_ready", tl_d_d_ready_o, ed.rdy);
        end
      end
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    tl_h_a_valid_i  = '0;
    tl_h_a_param_i  = '0;
    tl_h_a_size_i   = {4{2'd2}};
    tl_h_d_ready_i  = 4'hF;
    tl_h_a_mask_i   = '1;
    tl_d_a_ready_i  = 1'b1;
    tl_d_d_valid_i  = 1'b0;
    tl_d_d_opcode_i = 3'd1;
    tl_d_d_param_i  = '0;
    tl_d_d_size_i   = 2'd2;
    tl_d_d_source_i = '0;
    tl_d_d_sink_i   = 1'b0;
    tl_d_d_data_i   = '0;
    tl_d_d_error_i  = 1'b0;
    for (int i = 0; i < M; i++) begin
      tl_h_a_opcode_i[i*3 +: 3]    = 3'd4;
      tl_h_a_source_i[i*8 +: 8]    = hsrc[i];
      tl_h_a_address_i[i*32 +: 32] = 32'hA000_0000 + 32'(i) * 32'h100;
      tl_h_a_data_i[i*32 +: 32]    = 32'hC0DE_0000 + 32'(i);
    end

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
      end
    join_none

    // Reset: every valid/ready output forced low even with live inputs.
    cyc();
    cyc();
    tl_h_a_valid_i  = 4'hF;
    tl_d_d_valid_i  = 1'b1;
    tl_d_d_source_i = dsrc[0];
    @(negedge clk);
    chk("reset_grant", grant_o, 0);
    chk("reset_a_valid", tl_d_a_valid_o, 0);
    chk("reset_a_ready", tl_h_a_ready_o, 0);
    chk("reset_d_valid", tl_h_d_valid_o, 0);
    chk("reset_d_ready", tl_d_d_ready_o, 0);
    chk("reset_busy", busy_o, 0);
    cyc();
    rst_i          = 1'b0;
    tl_d_d_valid_i = 1'b0;

    // Round robin with all hosts requesting: 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      exp_a(k % 4);
      cyc();
    end
    tl_h_a_valid_i = '0;
    @(negedge clk);
    chk("rr_busy", busy_o, 1);
    cyc();

    // Drain; host2 response exercises source steering; host3 first stalled.
    respond(0, 32'hD000_0000); cyc();
    respond(0, 32'hD000_0001); cyc();
    respond(1, 32'hD000_0002); cyc();
    respond(2, 32'hD000_0003); cyc();
    tl_h_d_ready_i[3] = 1'b0;
    respond(3, 32'hD000_0004); cyc();
    tl_h_d_ready_i[3] = 1'b1;
    respond(3, 32'hD000_0004); cyc();
    tl_d_d_valid_i = 1'b0;
    @(negedge clk);
    chk("drain1_busy", busy_o, 0);
    cyc();

    // Grant lock: pointer at 1, device stalls three cycles.
    tl_h_a_valid_i = 4'b0111;
    tl_d_a_ready_i = 1'b0;
    exp_a(1); cyc();
    exp_a(1); cyc();
    exp_a(1); cyc();
    tl_d_a_ready_i = 1'b1;
    exp_a(1); cyc();
    tl_h_a_valid_i[1] = 1'b0;
    exp_a(2); cyc();
    tl_h_a_valid_i[2] = 1'b0;
    exp_a(0); cyc();
    tl_h_a_valid_i[0] = 1'b0;

    // Accept and response for host0 in one cycle with cnt0=1.
    tl_h_a_valid_i[0] = 1'b1;
    exp_a(0);
    respond(0, 32'hD000_0005);
    cyc();
    tl_h_a_valid_i = '0;
    tl_d_d_valid_i = 1'b0;
    @(negedge clk);
    chk("same_cycle_busy", busy_o, 1);
    cyc();
    respond(0, 32'hD000_0006); cyc();
    respond(1, 32'hD000_0007); cyc();
    respond(2, 32'hD000_0008); cyc();
    tl_d_d_valid_i = 1'b0;
    @(negedge clk);
    chk("drain2_busy", busy_o, 0);
    cyc();

    // Outstanding limit: host0 fills to 2, host3 wins, response frees host0.
    tl_h_a_valid_i[0] = 1'b1;
    exp_a(0); cyc();
    exp_a(0); cyc();
    tl_h_a_valid_i[3] = 1'b1;
    exp_a(3); cyc();
    tl_h_a_valid_i[3] = 1'b0;
    respond(0, 32'hD000_0009);
    @(negedge clk);
    chk("full_host_grant", grant_o, 0);
    cyc();
    tl_d_d_valid_i = 1'b0;
    exp_a(0); cyc();
    tl_h_a_valid_i[0] = 1'b0;

    // Build cnt={1,0,2,0}, lock on host0, then reset mid-lock.
    respond(0, 32'hD000_000A); cyc();
    respond(3, 32'hD000_000B); cyc();
    tl_d_d_valid_i    = 1'b0;
    tl_h_a_valid_i[2] = 1'b1;
    exp_a(2); cyc();
    exp_a(2); cyc();
    tl_h_a_valid_i[2] = 1'b0;
    tl_h_a_valid_i[0] = 1'b1;
    tl_d_a_ready_i    = 1'b0;
    exp_a(0); cyc();
    rst_i           = 1'b1;
    tl_d_d_valid_i  = 1'b1;
    tl_d_d_source_i = dsrc[2];
    @(negedge clk);
    chk("midlock_rst_grant", grant_o, 0);
    chk("midlock_rst_a_valid", tl_d_a_valid_o, 0);
    chk("midlock_rst_a_ready", tl_h_a_ready_o, 0);
    chk("midlock_rst_d_valid", tl_h_d_valid_o, 0);
    chk("midlock_rst_d_ready", tl_d_d_ready_o, 0);
    chk("midlock_rst_busy", busy_o, 0);
    cyc();
    rst_i          = 1'b0;
    tl_d_d_valid_i = 1'b0;
    tl_d_a_ready_i = 1'b1;
    tl_h_a_valid_i = 4'b1010;
    exp_a(1);
    @(negedge clk);
    chk("post_rst_busy", busy_o, 0);
    cyc();
    tl_h_a_valid_i = 4'b1000;
    exp_a(3); cyc();
    tl_h_a_valid_i = '0;
    cyc();
    cyc();

    chk("a_queue_left", a_q.size(), 0);
    chk("d_queue_left", d_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
